mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AGE_LIMIT, default 8, meaning the number of consecutive lost arbitrations after which fetch is forced to win.
REQ-002 SHALL have ports: clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 rdy  in  1  global enable; low = hold all state.
REQ-005 flush  in  1  branch-mispredict flush; cancels in-flight fetch result.
REQ-006 if_req  in  1; if_addr  in  32; if_done  out  1; if_data  out  32  (fetch requester, always 4 bytes).
REQ-007 ld_req  in  1; ld_addr  in  32; ld_qty  in  3; ld_done  out  1; ld_data  out  32  (load requester).
REQ-008 st_req  in  1; st_addr  in  32; st_qty  in  3; st_data  in  32; st_done  out  1  (store requester).
REQ-009 mc_req  out  1; mc_addr  out  32; mc_rw  out  1 (1 = write); mc_qty  out  3; mc_wdata  out  32; mc_done  in  1; mc_rdata  in  32  (memory-controller port).
REQ-010 owner  out  2  current grant: 0 none, 1 fetch, 2 load, 3 store.

Function
REQ-011 SHALL implement states IDLE, BUSY, RESP; IDLE->BUSY on any grant, BUSY->RESP on mc_done, RESP->IDLE unconditionally.
REQ-012 Requests SHALL be level signals, sampled only in IDLE; requester holds req/addr/qty/data stable until its done pulse and drops req on the edge ending that pulse.
REQ-013 Priority in IDLE SHALL be store > load > fetch, except fetch wins when age counter == AGE_LIMIT.
REQ-014 Age counter SHALL increment (saturating at AGE_LIMIT) on each IDLE grant to another requester while if_req=1, clear when fetch is granted, clear whenever if_req=0.
REQ-015 On grant, mc_addr/mc_rw/mc_qty/mc_wdata SHALL be registered from the winner and held constant through BUSY; fetch uses qty 4, rw 0.
REQ-016 Qty values other than 1 or 2 SHALL be forwarded as 4.
REQ-017 mc_req SHALL be 1 in every BUSY cycle and 0 otherwise; grant-to-mc_req latency one cycle.
REQ-018 In RESP the owning requester's done SHALL pulse for exactly one cycle; if_data/ld_data registered from mc_rdata with bytes above qty zeroed.
REQ-019 flush=1 while owner=fetch (BUSY or RESP) SHALL set a discard flag; if_done then stays 0 for that transaction; flag clears on return to IDLE.
REQ-020 flush=1 in IDLE SHALL suppress fetch grant that cycle; load/store grants unaffected; flush never affects load/store transactions.
REQ-021 mc_done outside BUSY SHALL be ignored.
REQ-022 rdy=0 SHALL freeze state, registers, outputs and age counter; mc_done and flush not sampled.
REQ-023 Minimum turnaround: transaction with mc_done in first BUSY cycle occupies 3 cycles (IDLE grant, BUSY, RESP).

Reset
REQ-024 rst=0 SHALL asynchronously force state IDLE, owner 0, all done/mc_req/mc_rw 0, mc_addr/mc_qty/mc_wdata/if_data/ld_data 0, age counter 0, discard flag 0.
REQ-025 Reset mid-transaction SHALL abandon it with no done pulse; no pending memory access is resumed.

Structure
REQ-026 AddrLen, RegLen, state encodings and owner IDs SHALL live in the shared defines header.
REQ-027 Priority/aging selection SHALL be one combinational sub-module mem_arb_prio (inputs three reqs, flush, age_full; output winner ID).

Verification
REQ-028 st_req, ld_req, if_req all 1 in same IDLE cycle -> store granted, mc_rw=1, st_done only; then load, then fetch, each separated by RESP.
REQ-029 ld_req held continuously with if_req=1, AGE_LIMIT=8 -> 8 load grants, 9th grant goes to fetch (owner=1).
REQ-030 Fetch if_addr=0x00001000, flush=1 in second BUSY cycle, mc_done with mc_rdata=0xDEADBEEF -> if_done stays 0, next IDLE samples cleanly.
REQ-031 Load ld_qty=1, mc_rdata=0x12345678 -> ld_data=0x00000078, ld_done one-cycle pulse in RESP; ld_qty=3 -> mc_qty=4.
REQ-032 rst=0 asserted mid-BUSY -> all outputs 0 immediately; after release with no reqs, mc_req stays 0.
REQ-033 rdy=0 for 5 cycles during BUSY with mc_done=1 -> no state change; on rdy=1 with mc_done=1 -> RESP next cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, encodings and helpers for the memory arbiter.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  localparam int AddrLen = 32;
  localparam int RegLen  = 32;
  localparam int QtyLen  = 3;

  // Access sizes understood by the memory controller (bytes).
  localparam logic [QtyLen-1:0] QtyByte = 3'd1;
  localparam logic [QtyLen-1:0] QtyHalf = 3'd2;
  localparam logic [QtyLen-1:0] QtyWord = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Owner IDs double as the value driven on the owner port.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2,
    OWN_STORE = 2'd3
  } owner_e;

  // Command latched on grant and presented to the memory controller.
  typedef struct packed {
    logic [AddrLen-1:0] addr;
    logic               rw;
    logic [QtyLen-1:0]  qty;
    logic [RegLen-1:0]  wdata;
  } mc_cmd_t;

  // Anything that is not a byte or halfword access is treated as a word.
  function automatic logic [QtyLen-1:0] norm_qty(input logic [QtyLen-1:0] q);
    if (q == QtyByte || q == QtyHalf) begin
      return q;
    end
    return QtyWord;
  endfunction

  // Zero read-data bytes above the access size.
  function automatic logic [RegLen-1:0] mask_rdata(input logic [RegLen-1:0] d,
                                                   input logic [QtyLen-1:0] q);
    case (q)
      QtyByte: return {{(RegLen-8){1'b0}}, d[7:0]};
      QtyHalf: return {{(RegLen-16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Picks the IDLE-cycle winner: store > load > fetch, with an aged fetch jumping the queue.
// Latency: purely combinational, zero cycles.
// Backpressure: none; a flush in the same cycle makes fetch ineligible.
module mem_arb_prio
  import mem_arbiter_pkg::*;
(
  input  logic   st_req_i,
  input  logic   ld_req_i,
  input  logic   if_req_i,
  input  logic   flush_i,
  input  logic   age_full_i,
  output owner_e winner_o
);

  logic fetch_ok;

  // A flushing front end must not start a fetch that would be thrown away.
  assign fetch_ok = if_req_i && !flush_i;

  // Fixed priority, overridden by a starving fetch.
  always_comb begin
    winner_o = OWN_NONE;
    if (fetch_ok && age_full_i) begin
      winner_o = OWN_FETCH;
    end else if (st_req_i) begin
      winner_o = OWN_STORE;
    end else if (ld_req_i) begin
      winner_o = OWN_LOAD;
    end else if (fetch_ok) begin
      winner_o = OWN_FETCH;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch/load/store requesters onto one memory-controller port.
// Latency: grant in IDLE, mc_req next cycle, done pulse one cycle after mc_done (3 cycles minimum).
// Backpressure: requesters wait on their done pulse; rdy=0 freezes the whole block.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AGE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               flush,
  // fetch requester
  input  logic               if_req,
  input  logic [AddrLen-1:0] if_addr,
  output logic               if_done,
  output logic [RegLen-1:0]  if_data,
  // load requester
  input  logic               ld_req,
  input  logic [AddrLen-1:0] ld_addr,
  input  logic [QtyLen-1:0]  ld_qty,
  output logic               ld_done,
  output logic [RegLen-1:0]  ld_data,
  // store requester
  input  logic               st_req,
  input  logic [AddrLen-1:0] st_addr,
  input  logic [QtyLen-1:0]  st_qty,
  input  logic [RegLen-1:0]  st_data,
  output logic               st_done,
  // memory controller
  output logic               mc_req,
  output logic [AddrLen-1:0] mc_addr,
  output logic               mc_rw,
  output logic [QtyLen-1:0]  mc_qty,
  output logic [RegLen-1:0]  mc_wdata,
  input  logic               mc_done,
  input  logic [RegLen-1:0]  mc_rdata,
  // current grant
  output logic [1:0]         owner
);

  localparam int AgeW = (AGE_LIMIT < 1) ? 1 : $clog2(AGE_LIMIT + 1);
  localparam logic [AgeW-1:0] AgeMax = AgeW'(AGE_LIMIT);

  state_e             state_q,   state_d;
  owner_e             owner_q,   owner_d;
  mc_cmd_t            cmd_q,     cmd_d;
  logic [AgeW-1:0]    age_q,     age_d;
  logic               discard_q, discard_d;
  logic               if_done_q, if_done_d;
  logic               ld_done_q, ld_done_d;
  logic               st_done_q, st_done_d;
  logic [RegLen-1:0]  if_data_q, if_data_d;
  logic [RegLen-1:0]  ld_data_q, ld_data_d;

  owner_e             winner;
  logic               age_full;
  logic               fetch_flushed;

  assign age_full      = (age_q == AgeMax);
  // Flush only ever cancels a fetch; loads and stores run to completion.
  assign fetch_flushed = flush && (owner_q == OWN_FETCH);

  mem_arb_prio u_prio (
    .st_req_i   (st_req),
    .ld_req_i   (ld_req),
    .if_req_i   (if_req),
    .flush_i    (flush),
    .age_full_i (age_full),
    .winner_o   (winner)
  );

  // Next-state, command capture, response capture and fetch aging.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cmd_d     = cmd_q;
    age_d     = age_q;
    discard_d = discard_q;
    if_done_d = if_done_q;
    ld_done_d = ld_done_q;
    st_done_d = st_done_q;
    if_data_d = if_data_q;
    ld_data_d = ld_data_q;

    // With rdy low every register keeps its value, including done pulses.
    if (rdy) begin
      if_done_d = 1'b0;
      ld_done_d = 1'b0;
      st_done_d = 1'b0;

      // A fetch that is no longer asking has nothing to starve.
      if (!if_req) begin
        age_d = '0;
      end

      unique case (state_q)
        ST_IDLE: begin
          discard_d = 1'b0;
          if (winner != OWN_NONE) begin
            state_d = ST_BUSY;
            owner_d = winner;
            case (winner)
              OWN_FETCH: cmd_d = '{addr: if_addr, rw: 1'b0, qty: QtyWord,
                                   wdata: '0};
              OWN_LOAD:  cmd_d = '{addr: ld_addr, rw: 1'b0, qty: norm_qty(ld_qty),
                                   wdata: '0};
              OWN_STORE: cmd_d = '{addr: st_addr, rw: 1'b1, qty: norm_qty(st_qty),
                                   wdata: st_data};
              default:   cmd_d = cmd_q;
            endcase
            // Fetch was waiting and someone else got the port: it ages.
            if (if_req) begin
              if (winner == OWN_FETCH) begin
                age_d = '0;
              end else if (!age_full) begin
                age_d = age_q + AgeW'(1);
              end
            end
          end
        end

        ST_BUSY: begin
          if (fetch_flushed) begin
            discard_d = 1'b1;
          end
          if (mc_done) begin
            state_d = ST_RESP;
            case (owner_q)
              OWN_FETCH: begin
                // A flush arriving with mc_done kills the result as well.
                if (!discard_q && !flush) begin
                  if_done_d = 1'b1;
                  if_data_d = mask_rdata(mc_rdata, cmd_q.qty);
                end
              end
              OWN_LOAD: begin
                ld_done_d = 1'b1;
                ld_data_d = mask_rdata(mc_rdata, cmd_q.qty);
              end
              OWN_STORE: begin
                st_done_d = 1'b1;
              end
              default: begin
              end
            endcase
          end
        end

        ST_RESP: begin
          // The done pulse is visible this cycle; the grant ends here.
          state_d   = ST_IDLE;
          owner_d   = OWN_NONE;
          discard_d = 1'b0;
        end

        default: begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end
      endcase
    end
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_NONE;
      cmd_q     <= '0;
      age_q     <= '0;
      discard_q <= 1'b0;
      if_done_q <= 1'b0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
      if_data_q <= '0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cmd_q     <= cmd_d;
      age_q     <= age_d;
      discard_q <= discard_d;
      if_done_q <= if_done_d;
      ld_done_q <= ld_done_d;
      st_done_q <= st_done_d;
      if_data_q <= if_data_d;
      ld_data_q <= ld_data_d;
    end
  end

  assign mc_req   = (state_q == ST_BUSY);
  assign mc_addr  = cmd_q.addr;
  assign mc_rw    = cmd_q.rw;
  assign mc_qty   = cmd_q.qty;
  assign mc_wdata = cmd_q.wdata;
  assign owner    = owner_q;
  assign if_done  = if_done_q;
  assign ld_done  = ld_done_q;
  assign st_done  = st_done_q;
  assign if_data  = if_data_q;
  assign ld_data  = ld_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: grants are predicted into a scoreboard
// queue as requests are raised and popped when mc_req shows the DUT's choice.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_mem_arbiter;

  localparam int AGE = 8;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        if_req;  logic [31:0] if_addr;  logic if_done;  logic [31:0] if_data;
  logic        ld_req;  logic [31:0] ld_addr;  logic [2:0] ld_qty;
  logic        ld_done; logic [31:0] ld_data;
  logic        st_req;  logic [31:0] st_addr;  logic [2:0] st_qty;
  logic [31:0] st_data; logic        st_done;
  logic        mc_req;  logic [31:0] mc_addr;  logic mc_rw; logic [2:0] mc_qty;
  logic [31:0] mc_wdata;
  logic        mc_done; logic [31:0] mc_rdata;
  logic [1:0]  owner;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  own;
    logic [31:0] addr;
    logic        rw;
    logic [2:0]  qty;
    logic [31:0] wdata;
    logic [31:0] rdata;   // value the memory model returns
    logic [31:0] rexp;    // value the requester must see
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_arbiter #(.AGE_LIMIT(AGE)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_qty(ld_qty), .ld_done(ld_done),
    .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_qty(st_qty), .st_data(st_data),
    .st_done(st_done),
    .mc_req(mc_req), .mc_addr(mc_addr), .mc_rw(mc_rw), .mc_qty(mc_qty),
    .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata),
    .owner(owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles until mc_req rises (0 if it never does within the budget).
  task automatic wait_req(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (mc_req === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    n_tests++;
    if ({mc_req, mc_rw, owner, if_done, ld_done, st_done} !== 7'b0) begin
      $display("FAIL reset_ctrl: got %b, want 0", {mc_req, mc_rw, owner, if_done, ld_done, st_done});
      n_fail++;
    end
    n_tests++;
    if ({mc_addr, mc_qty, mc_wdata, if_data, ld_data} !== 131'b0) begin
      $display("FAIL reset_data: addr=%h qty=%0d wdata=%h if=%h ld=%h, want 0",
               mc_addr, mc_qty, mc_wdata, if_data, ld_data);
      n_fail++;
    end
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (mc_req !== 1'b0 || owner !== 2'd0) begin
      $display("FAIL reset_idle: mc_req=%b owner=%0d, want 0/0", mc_req, owner);
      n_fail++;
    end
  endtask

  task automatic test_priority();
    exp_t e; int cyc; logic [2:0] dn_exp; logic [31:0] got;
    sb.delete();
    st_addr = 32'h0000_0100; st_qty = 3'd2; st_data = 32'h1122_3344;
    ld_addr = 32'h0000_0200; ld_qty = 3'd1;
    if_addr = 32'h0000_0300;
    sb.push_back('{2'd3, 32'h100, 1'b1, 3'd2, 32'h11223344, 32'hFFFF_FFFF, 32'h0});
    sb.push_back('{2'd2, 32'h200, 1'b0, 3'd1, 32'h0, 32'h12345678, 32'h00000078});
    sb.push_back('{2'd1, 32'h300, 1'b0, 3'd4, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D});
    st_req = 1'b1; ld_req = 1'b1; if_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_req(cyc);
      n_tests++;
      if (cyc != 1) begin
        $display("FAIL prio_latency[%0d]: got %0d cycles, want 1", k, cyc);
        n_fail++;
        if (cyc == 0) return;
      end
      e = sb.pop_front();
      n_tests++;
      if (owner !== e.own || mc_addr !== e.addr || mc_rw !== e.rw ||
          mc_qty !== e.qty || mc_wdata !== e.wdata) begin
        $display("FAIL prio_grant[%0d]: got own=%0d addr=%h rw=%b qty=%0d wd=%h, want own=%0d addr=%h rw=%b qty=%0d wd=%h",
                 k, owner, mc_addr, mc_rw, mc_qty, mc_wdata, e.own, e.addr, e.rw, e.qty, e.wdata);
        n_fail++;
      end
      mc_done = 1'b1; mc_rdata = e.rdata;
      tick();
      mc_done = 1'b0;
      dn_exp = (e.own == 2'd1) ? 3'b100 : (e.own == 2'd2) ? 3'b010 : 3'b001;
      n_tests++;
      if ({if_done, ld_done, st_done} !== dn_exp || mc_req !== 1'b0) begin
        $display("FAIL prio_done[%0d]: got done=%b mc_req=%b, want done=%b mc_req=0",
                 k, {if_done, ld_done, st_done}, mc_req, dn_exp);
        n_fail++;
      end
      if (e.own != 2'd3) begin
        got = (e.own == 2'd1) ? if_data : ld_data;
        n_tests++;
        if (got !== e.rexp) begin
          $display("FAIL prio_rdata[%0d]: got %h, want %h", k, got, e.rexp);
          n_fail++;
        end
      end
      case (e.own)
        2'd1:    if_req = 1'b0;
        2'd2:    ld_req = 1'b0;
        default: st_req = 1'b0;
      endcase
      tick();
      n_tests++;
      if ({if_done, ld_done, st_done} !== 3'b000 || owner !== 2'd0) begin
        $display("FAIL prio_release[%0d]: got done=%b owner=%0d, want 000/0",
                 k, {if_done, ld_done, st_done}, owner);
        n_fail++;
      end
    end
  endtask

  task automatic test_aging();
    exp_t e; int cyc;
    sb.delete();
    ld_addr = 32'h0000_0400; ld_qty = 3'd3; if_addr = 32'h0000_0500;
    for (int k = 0; k < AGE; k++)
      sb.push_back('{2'd2, 32'h400, 1'b0, 3'd4, 32'h0, 32'h0, 32'h0});
    sb.push_back('{2'd1, 32'h500, 1'b0, 3'd4, 32'h0, 32'h0, 32'h0});
    ld_req = 1'b1; if_req = 1'b1;
    for (int k = 0; k <= AGE; k++) begin
      wait_req(cyc);
      e = sb.pop_front();
      n_tests++;
      if (cyc == 0 || owner !== e.own || mc_addr !== e.addr || mc_qty !== e.qty) begin
        $display("FAIL aging_grant[%0d]: got cyc=%0d own=%0d addr=%h qty=%0d, want own=%0d addr=%h qty=%0d",
                 k, cyc, owner, mc_addr, mc_qty, e.own, e.addr, e.qty);
        n_fail++;
        if (cyc == 0) return;
      end
      mc_done = 1'b1; mc_rdata = 32'h0;
      tick();
      mc_done = 1'b0;
      if (k == AGE) begin
        if_req = 1'b0; ld_req = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_flush();
    exp_t e; int cyc;
    if_addr = 32'h0000_1000; if_req = 1'b1;
    tick();
    n_tests++;
    if (mc_req !== 1'b1 || owner !== 2'd1 || mc_addr !== 32'h0000_1000) begin
      $display("FAIL flush_grant: got mc_req=%b own=%0d addr=%h, want 1/1/00001000",
               mc_req, owner, mc_addr);
      n_fail++;
    end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; mc_done = 1'b1; mc_rdata = 32'hDEADBEEF;
    tick();
    mc_done = 1'b0; if_req = 1'b0;
    n_tests++;
    if (if_done !== 1'b0 || owner !== 2'd1 || mc_req !== 1'b0) begin
      $display("FAIL flush_resp: got if_done=%b own=%0d mc_req=%b, want 0/1/0",
               if_done, owner, mc_req);
      n_fail++;
    end
    tick();
    n_tests++;
    if (if_done !== 1'b0 || owner !== 2'd0) begin
      $display("FAIL flush_idle: got if_done=%b own=%0d, want 0/0", if_done, owner);
      n_fail++;
    end

    // Flush in IDLE holds off the fetch; the next clean IDLE grants it normally.
    sb.delete();
    sb.push_back('{2'd1, 32'h2000, 1'b0, 3'd4, 32'h0, 32'h0BADF00D, 32'h0BADF00D});
    if_addr = 32'h0000_2000; if_req = 1'b1; flush = 1'b1;
    tick();
    n_tests++;
    if (mc_req !== 1'b0 || owner !== 2'd0) begin
      $display("FAIL flush_idle_block: got mc_req=%b own=%0d, want 0/0", mc_req, owner);
      n_fail++;
    end
    flush = 1'b0;
    wait_req(cyc);
    e = sb.pop_front();
    n_tests++;
    if (cyc != 1 || owner !== e.own || mc_addr !== e.addr) begin
      $display("FAIL flush_regrant: got cyc=%0d own=%0d addr=%h, want 1/%0d/%h",
               cyc, owner, mc_addr, e.own, e.addr);
      n_fail++;
      if (cyc == 0) return;
    end
    mc_done = 1'b1; mc_rdata = e.rdata;
    tick();
    mc_done = 1'b0; if_req = 1'b0;
    n_tests++;
    if (if_done !== 1'b1 || if_data !== e.rexp) begin
      $display("FAIL flush_clean_fetch: got if_done=%b data=%h, want 1/%h", if_done, if_data, e.rexp);
      n_fail++;
    end
    tick();

    // Flush never touches a load, whether at grant or in flight.
    ld_addr = 32'h0000_2400; ld_qty = 3'd4; ld_req = 1'b1; flush = 1'b1;
    tick();
    n_tests++;
    if (mc_req !== 1'b1 || owner !== 2'd2) begin
      $display("FAIL flush_load_grant: got mc_req=%b own=%0d, want 1/2", mc_req, owner);
      n_fail++;
    end
    mc_done = 1'b1; mc_rdata = 32'h7654_3210;
    tick();
    mc_done = 1'b0; ld_req = 1'b0; flush = 1'b0;
    n_tests++;
    if (ld_done !== 1'b1 || ld_data !== 32'h7654_3210) begin
      $display("FAIL flush_load_done: got ld_done=%b data=%h, want 1/76543210", ld_done, ld_data);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_rdy_freeze();
    ld_addr = 32'h0000_3000; ld_qty = 3'd2; ld_req = 1'b1;
    tick();
    rdy = 1'b0; mc_done = 1'b1; mc_rdata = 32'hA5A5_1234;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if (mc_req !== 1'b1 || owner !== 2'd2 || ld_done !== 1'b0 || mc_addr !== 32'h0000_3000) begin
        $display("FAIL rdy_hold[%0d]: got mc_req=%b own=%0d ld_done=%b addr=%h, want 1/2/0/00003000",
                 k, mc_req, owner, ld_done, mc_addr);
        n_fail++;
      end
    end
    rdy = 1'b1;
    tick();
    ld_req = 1'b0;
    n_tests++;
    if (ld_done !== 1'b1 || ld_data !== 32'h0000_1234 || mc_req !== 1'b0) begin
      $display("FAIL rdy_resume: got ld_done=%b data=%h mc_req=%b, want 1/00001234/0",
               ld_done, ld_data, mc_req);
      n_fail++;
    end
    // mc_done left high through RESP and IDLE must be ignored.
    tick();
    tick();
    n_tests++;
    if (mc_req !== 1'b0 || owner !== 2'd0 || {if_done, ld_done, st_done} !== 3'b000) begin
      $display("FAIL stray_mc_done: got mc_req=%b own=%0d done=%b, want 0/0/000",
               mc_req, owner, {if_done, ld_done, st_done});
      n_fail++;
    end
    mc_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic seen;
    st_addr = 32'h0000_4000; st_qty = 3'd4; st_data = 32'h55AA_55AA; st_req = 1'b1;
    tick();
    n_tests++;
    if (mc_req !== 1'b1 || owner !== 2'd3 || mc_rw !== 1'b1) begin
      $display("FAIL rstmid_grant: got mc_req=%b own=%0d rw=%b, want 1/3/1", mc_req, owner, mc_rw);
      n_fail++;
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({mc_req, mc_rw, owner, st_done, mc_addr, mc_qty, mc_wdata} !== 72'b0) begin
      $display("FAIL rstmid_async: got mc_req=%b rw=%b own=%0d st_done=%b addr=%h qty=%0d wd=%h, want 0",
               mc_req, mc_rw, owner, st_done, mc_addr, mc_qty, mc_wdata);
      n_fail++;
    end
    st_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen = seen | mc_req | st_done;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      $display("FAIL rstmid_resume: got mc_req/st_done activity=%b, want 0", seen);
      n_fail++;
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ld_req = 1'b0; ld_addr = '0; ld_qty = '0;
    st_req = 1'b0; st_addr = '0; st_qty = '0; st_data = '0;
    mc_done = 1'b0; mc_rdata = '0;
    #3;
    test_reset();
    test_priority();
    test_aging();
    test_flush();
    test_rdy_freeze();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
